pwl_synth_host_if: RTL and testbench

- Host-side initiator for the synth chip's pin-level register port.
- Turns a simple register request (8-bit address, 16-bit data, read or write) into the edge-coded command sequence on the chip's cmd/data pins.
- For reads, waits on the chip's busy flag and fetches the 16-bit result one byte at a time through the read-select pin.
- Used in the FPGA test harness and demo board controller, clocked in the same domain as the chip.

---
 rtl/pwl_synth_host_if.sv | 176 +++++++++++++++++
 tb/tb_pwl_synth_host_if.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwl_synth_host_if.sv
// Host-side initiator for the synth chip register port: turns a register request into
// edge-coded cmd/data pin phases, polls busy for reads and fetches the result bytewise.
module pwl_synth_host_if #(
  parameter int STEP_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  pin_data,
  output logic [3:0]  pin_cmd,
  output logic        pin_read_sel,
  input  logic [7:0]  pin_rdata,
  input  logic        pin_busy
);

  localparam logic [7:0]  STEP_LAST = 8'(STEP_CYCLES - 1);
  localparam logic [10:0] TO_LAST   = 11'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, LO_SET, LO_CLR, HI_SET, HI_CLR, CMD_SET, CMD_CLR,
    WAIT_BUSY, RD_LO, RD_HI, RESP
  } state_t;

  state_t state, state_next;

  logic [7:0]  phase;
  logic [10:0] tmo;
  logic        busy_meta, busy_sync;
  logic [7:0]  rdata_in;
  logic        is_write, skip_hi;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [7:0]  shadow_lo, shadow_hi;
  logic        shadow_valid;
  logic [15:0] rdata_acc;
  logic        err_flag;

  logic        accept, phase_done, timed_out, lo_match, hi_match;
  logic [3:0]  cmd_d;
  logic [7:0]  data_d;

  assign accept     = req_valid && req_ready && (state == IDLE);
  assign phase_done = (phase == STEP_LAST);
  assign timed_out  = (tmo == TO_LAST);
  assign lo_match   = shadow_valid && (req_wdata[7:0] == shadow_lo);
  assign hi_match   = shadow_valid && (req_wdata[15:8] == shadow_hi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_d      = 4'b0000;
    data_d     = pin_data;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!req_write)     state_next = CMD_SET;
          else if (!lo_match) state_next = LO_SET;
          else if (!hi_match) state_next = HI_SET;
          else                state_next = CMD_SET;
        end
      end
      LO_SET: begin
        cmd_d  = 4'b0001;
        data_d = wdata[7:0];
        if (phase_done) state_next = LO_CLR;
      end
      LO_CLR: begin
        data_d = wdata[7:0];
        if (phase_done) state_next = skip_hi ? CMD_SET : HI_SET;
      end
      HI_SET: begin
        cmd_d  = 4'b0010;
        data_d = wdata[15:8];
        if (phase_done) state_next = HI_CLR;
      end
      HI_CLR: begin
        data_d = wdata[15:8];
        if (phase_done) state_next = CMD_SET;
      end
      CMD_SET: begin
        cmd_d  = is_write ? 4'b0100 : 4'b1000;
        data_d = addr;
        if (phase_done) state_next = CMD_CLR;
      end
      CMD_CLR: begin
        data_d = addr;
        if (phase_done) state_next = is_write ? RESP : WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!busy_sync)     state_next = RD_LO;
        else if (timed_out) state_next = RESP;
      end
      RD_LO:   if (phase_done) state_next = RD_HI;
      RD_HI:   if (phase_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase        <= '0;
      tmo          <= '0;
      busy_meta    <= 1'b0;
      busy_sync    <= 1'b0;
      rdata_in     <= '0;
      is_write     <= 1'b0;
      skip_hi      <= 1'b0;
      addr         <= '0;
      wdata        <= '0;
      shadow_lo    <= '0;
      shadow_hi    <= '0;
      shadow_valid <= 1'b0;
      rdata_acc    <= '0;
      err_flag     <= 1'b0;
      pin_cmd      <= '0;
      pin_data     <= '0;
      pin_read_sel <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      req_ready    <= 1'b1;
    end else begin
      busy_meta <= pin_busy;
      busy_sync <= busy_meta;
      rdata_in  <= pin_rdata;

      if (state_next != state) phase <= '0;
      else if (phase != 8'hff) phase <= phase + 8'd1;

      // Saturates so a very long TIMEOUT_CYCLES setting can never wrap back to zero.
      if (state != WAIT_BUSY)   tmo <= '0;
      else if (tmo != 11'h7ff)  tmo <= tmo + 11'd1;

      if (accept) begin
        is_write  <= req_write;
        addr      <= req_addr;
        wdata     <= req_wdata;
        skip_hi   <= req_write && hi_match;
        rdata_acc <= '0;
        err_flag  <= 1'b0;
      end

      if (state == RD_LO && phase_done) rdata_acc[7:0]  <= rdata_in;
      if (state == RD_HI && phase_done) rdata_acc[15:8] <= rdata_in;
      if (state == WAIT_BUSY && busy_sync && timed_out) err_flag <= 1'b1;

      if (state == CMD_CLR && phase_done && is_write) begin
        shadow_lo    <= wdata[7:0];
        shadow_hi    <= wdata[15:8];
        shadow_valid <= 1'b1;
      end

      pin_cmd      <= cmd_d;
      pin_data     <= data_d;
      pin_read_sel <= (state == RD_HI);
      rsp_valid    <= (state == RESP);
      rsp_err      <= (state == RESP) && err_flag;
      rsp_rdata    <= (state == RESP) ? rdata_acc : 16'h0000;
      req_ready    <= (state == IDLE) && !accept;
    end
  end

endmodule

// File: tb/tb_pwl_synth_host_if.sv
// Bench for pwl_synth_host_if: a behavioural chip model on the pins plus a register-map
// reference model; directed steps followed by randomized traffic.
module tb_pwl_synth_host_if;

  localparam int STEP = 4;
  localparam int TMO  = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic [7:0]  pin_data, pin_rdata;
  logic [3:0]  pin_cmd;
  logic        pin_read_sel, pin_busy;

  always #5 clk = ~clk;

  pwl_synth_host_if #(.STEP_CYCLES(STEP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pin_data(pin_data), .pin_cmd(pin_cmd), .pin_read_sel(pin_read_sel),
    .pin_rdata(pin_rdata), .pin_busy(pin_busy)
  );

  // Chip model: acts on rising cmd edges, busy for busy_len cycles after a read command.
  logic [15:0] chip_regs [256];
  logic [7:0]  chip_lo = '0, chip_hi = '0;
  logic [15:0] chip_rd = '0;
  logic [3:0]  prev_cmd = '0;
  int          busy_left = 0;
  int          busy_len = 0;
  logic        busy_stuck = 1'b0;

  assign pin_rdata = pin_read_sel ? chip_rd[15:8] : chip_rd[7:0];
  assign pin_busy  = busy_stuck || (busy_left > 0);

  always @(posedge clk) begin
    prev_cmd <= pin_cmd;
    if (pin_cmd[0] && !prev_cmd[0]) chip_lo <= pin_data;
    if (pin_cmd[1] && !prev_cmd[1]) chip_hi <= pin_data;
    if (pin_cmd[2] && !prev_cmd[2]) chip_regs[pin_data] <= {chip_hi, chip_lo};
    if (pin_cmd[3] && !prev_cmd[3]) begin
      chip_rd   <= chip_regs[pin_data];
      busy_left <= busy_len;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end
  end

  // Reference model: register contents and last bytes delivered to the chip.
  logic [15:0] m_regs [256];
  logic        m_shv;
  logic [7:0]  m_shlo, m_shhi;

  typedef logic [12:0] smp_t;  // {cmd, data, read_sel}
  smp_t tr[$];
  smp_t ex[$];

  typedef struct { logic wr; logic [15:0] rd; } pend_t;
  pend_t pend[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic smp_t mk(input logic [3:0] c, input logic [7:0] d, input logic s);
    return {c, d, s};
  endfunction

  task automatic push_phase(input logic [3:0] c, input logic [7:0] d);
    for (int i = 0; i < STEP; i++) ex.push_back(mk(c, d, 1'b0));
    for (int i = 0; i < STEP; i++) ex.push_back(mk(4'b0000, d, 1'b0));
  endtask

  // Offers one request, returns latency from acceptance to rsp_valid and the response.
  task automatic run_req(input logic wr, input logic [7:0] a, input logic [15:0] d,
                         input int blen, input logic stuck,
                         output int lat, output logic [15:0] rd, output logic er);
    int w;
    int n;
    busy_len   = blen;
    busy_stuck = stuck;
    req_write  = wr;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = 16'($urandom);
    tr.delete();
    n = 1;
    while (!rsp_valid && n < 3000) begin
      if (n >= 2) tr.push_back(mk(pin_cmd, pin_data, pin_read_sel));
      @(negedge clk);
      n++;
    end
    check("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    lat = n - 1;
    rd  = rsp_rdata;
    er  = rsp_err;
    @(negedge clk);
    check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    check("ready_after_rsp", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    logic lo_send, hi_send;
    int lat;
    logic [15:0] rd;
    logic er;
    lo_send = !(m_shv && d[7:0] == m_shlo);
    hi_send = !(m_shv && d[15:8] == m_shhi);
    ex.delete();
    if (lo_send) push_phase(4'b0001, d[7:0]);
    if (hi_send) push_phase(4'b0010, d[15:8]);
    push_phase(4'b0100, a);
    run_req(1'b1, a, d, 0, 1'b0, lat, rd, er);
    check("wr_latency", lat, 1 + 2 * STEP * (1 + int'(lo_send) + int'(hi_send)));
    check("wr_trace_len", tr.size(), ex.size());
    for (int i = 0; i < ex.size() && i < tr.size(); i++)
      check($sformatf("wr_trace[%0d]", i), {19'd0, tr[i]}, {19'd0, ex[i]});
    check("wr_rdata", {16'd0, rd}, 32'd0);
    check("wr_err", {31'd0, er}, 32'd0);
    m_regs[a] = d;
    m_shv  = 1'b1;
    m_shlo = d[7:0];
    m_shhi = d[15:8];
  endtask

  task automatic do_read(input logic [7:0] a, input int blen);
    int lat, c_rd, c_sel;
    logic [15:0] rd;
    logic er;
    run_req(1'b0, a, 16'h0, blen, 1'b0, lat, rd, er);
    check("rd_rdata", {16'd0, rd}, {16'd0, m_regs[a]});
    check("rd_err", {31'd0, er}, 32'd0);
    c_rd = 0;
    c_sel = 0;
    foreach (tr[i]) begin
      if (tr[i][12:9] == 4'b1000) c_rd++;
      if (tr[i][0]) c_sel++;
    end
    check("rd_cmd_cycles", c_rd, STEP);
    check("rd_sel_cycles", c_sel, STEP);
    if (tr.size() > STEP) begin
      check("rd_sel_last", {31'd0, tr[tr.size()-1][0]}, 32'd1);
      check("rd_sel_lo_before", {31'd0, tr[tr.size()-1-STEP][0]}, 32'd0);
    end
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'h34;
      2:       return 8'h12;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int lat, w, pulses, accepted, responded;
    logic [15:0] rd;
    logic er;
    pend_t p;

    for (int i = 0; i < 256; i++) begin
      chip_regs[i] = 16'h0000;
      m_regs[i]    = 16'h0000;
    end
    chip_regs[8'h10] = 16'hBEEF;
    m_regs[8'h10]    = 16'hBEEF;
    m_shv = 1'b0; m_shlo = '0; m_shhi = '0;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pin_cmd", {28'd0, pin_cmd}, 32'd0);
    check("rst_pin_data", {24'd0, pin_data}, 32'd0);
    check("rst_read_sel", {31'd0, pin_read_sel}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    do_write(8'h05, 16'h1234);
    do_write(8'h06, 16'h1299);
    do_read(8'h10, 3);

    run_req(1'b0, 8'h10, 16'h0, 0, 1'b1, lat, rd, er);
    check("to_err", {31'd0, er}, 32'd1);
    check("to_rdata", {16'd0, rd}, 32'd0);
    check("to_latency", lat, 1 + 2 * STEP + TMO);
    busy_stuck = 1'b0;

    // Abort a write in its high-byte phase.
    req_write = 1'b1; req_addr = 8'h07; req_wdata = 16'h5678; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (pin_cmd != 4'b0010 && w < 100) begin @(negedge clk); w++; end
    check("abort_reached_hi_set", {28'd0, pin_cmd}, 32'd2);
    rst = 1'b1;
    #1;
    check("abort_pin_cmd", {28'd0, pin_cmd}, 32'd0);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("abort_no_rsp", pulses, 0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    m_shv = 1'b0;
    do_write(8'h08, 16'h1234);

    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 1) == 1) do_write(8'($urandom_range(0, 7)), {pick_byte(), pick_byte()});
      else                           do_read(8'($urandom_range(0, 7)), int'($urandom_range(0, 6)));
    end

    // req_valid held high; fields churn while the block is busy.
    busy_len = 2;
    accepted = 0;
    responded = 0;
    req_valid = 1'b1;
    req_write = 1'($urandom); req_addr = 8'($urandom_range(0, 7)); req_wdata = 16'($urandom);
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (rsp_valid) begin
        responded++;
        if (pend.size() > 0) begin
          p = pend.pop_front();
          check("hold_rdata", {16'd0, rsp_rdata}, {16'd0, p.rd});
          check("hold_err", {31'd0, rsp_err}, 32'd0);
        end
      end
      if (cyc >= 500) req_valid = 1'b0;
      if (req_valid && req_ready) begin
        accepted++;
        p.wr = req_write;
        p.rd = req_write ? 16'h0000 : m_regs[req_addr];
        pend.push_back(p);
        if (req_write) m_regs[req_addr] = req_wdata;
      end else begin
        req_write = 1'($urandom);
        req_addr  = 8'($urandom_range(0, 7));
        req_wdata = {pick_byte(), pick_byte()};
      end
      @(negedge clk);
    end
    check("hold_rsp_count", responded, accepted);
    check("hold_pending_empty", pend.size(), 0);
    check("hold_some_accepted", {31'd0, accepted > 10}, 32'd1);
    for (int i = 0; i < 8; i++)
      check($sformatf("chip_reg[%0d]", i), {16'd0, chip_regs[i]}, {16'd0, m_regs[i]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
